exu_seq: RTL and testbench

- Multi-cycle execute sequencer for the NPC core.
- Accepts one decoded instruction at a time from decode over a valid/ready handshake, then drives the shared integer ALU's operands and op enable for a fixed number of cycles.
- Issues a single-cycle register writeback and commit pulse for each instruction.
- On ebreak, stops the core in a sticky HALT state. Also keeps cycle and retired-instruction counters for the simulation environment.

---
 rtl/exu_seq.sv | 117 +++++++++++
 tb/tb_exu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_seq.sv
// Multi-cycle execute sequencer: accepts one decoded instruction, drives the ALU for ALU_LAT cycles, then writes back and commits.
module exu_seq #(
  parameter int XLEN    = 64,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rd,
  input  logic             in_add,
  input  logic             in_ebreak,
  output logic [XLEN-1:0]  alu_src1,
  output logic [XLEN-1:0]  alu_imm,
  output logic             alu_add,
  input  logic [XLEN-1:0]  alu_result,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             commit,
  output logic [XLEN-1:0]  commit_pc,
  output logic             halted,
  output logic [XLEN-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rd_q;
  logic            add_q;
  logic            in_ready_q;

  assign in_ready = in_ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      add_q      <= 1'b0;
      in_ready_q <= 1'b1;
      alu_add    <= 1'b0;
      alu_src1   <= '0;
      alu_imm    <= '0;
      wb_en      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      commit     <= 1'b0;
      commit_pc  <= '0;
      halted     <= 1'b0;
      halt_pc    <= '0;
      cycle_cnt  <= '0;
      instret    <= '0;
    end else begin
      if (!halted) cycle_cnt <= cycle_cnt + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            pc_q       <= in_pc;
            rd_q       <= in_rd;
            add_q      <= in_add;
            alu_src1   <= in_src1;
            alu_imm    <= in_imm;
            in_ready_q <= 1'b0;
            // ebreak wins over addi when decode flags both
            if (in_ebreak) begin
              state_q <= HALT;
              halted  <= 1'b1;
              halt_pc <= in_pc;
              instret <= instret + 1'b1;
            end else begin
              state_q <= EXEC;
              cnt_q   <= LAT_M1;
              alu_add <= in_add;
            end
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q   <= WB;
            alu_add   <= 1'b0;
            wb_data   <= alu_result;
            wb_rd     <= rd_q;
            wb_en     <= add_q && (rd_q != 5'd0);
            commit    <= 1'b1;
            commit_pc <= pc_q;
            instret   <= instret + 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WB: begin
          state_q    <= IDLE;
          wb_en      <= 1'b0;
          commit     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq: instance A uses ALU_LAT=1, instance B uses ALU_LAT=3.
module tb_exu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;
  int halt_cyc;

  // Instance A signals (ALU_LAT = 1)
  logic        a_rstn = 1'b0, a_valid = 1'b0, a_ready, a_add = 1'b0, a_ebreak = 1'b0;
  logic [63:0] a_pc = '0, a_src1 = '0, a_imm = '0;
  logic [4:0]  a_rd = '0;
  logic [63:0] a_alu_src1, a_alu_imm, a_alu_result, a_wb_data, a_commit_pc, a_halt_pc;
  logic        a_alu_add, a_wb_en, a_commit, a_halted;
  logic [4:0]  a_wb_rd;
  logic [63:0] a_cycle_cnt, a_instret;

  // Instance B signals (ALU_LAT = 3)
  logic        b_rstn = 1'b0, b_valid = 1'b0, b_ready, b_add = 1'b0, b_ebreak = 1'b0;
  logic [63:0] b_pc = '0, b_src1 = '0, b_imm = '0;
  logic [4:0]  b_rd = '0;
  logic [63:0] b_alu_src1, b_alu_imm, b_alu_result, b_wb_data, b_commit_pc, b_halt_pc;
  logic        b_alu_add, b_wb_en, b_commit, b_halted;
  logic [4:0]  b_wb_rd;
  logic [63:0] b_cycle_cnt, b_instret;

  assign a_alu_result = a_alu_src1 + a_alu_imm;
  assign b_alu_result = b_alu_src1 + b_alu_imm;

  exu_seq #(.XLEN(64), .ALU_LAT(1), .CNT_W(64)) dut_a (
    .clk(clk), .rstn(a_rstn), .in_valid(a_valid), .in_ready(a_ready),
    .in_pc(a_pc), .in_src1(a_src1), .in_imm(a_imm), .in_rd(a_rd),
    .in_add(a_add), .in_ebreak(a_ebreak),
    .alu_src1(a_alu_src1), .alu_imm(a_alu_imm), .alu_add(a_alu_add), .alu_result(a_alu_result),
    .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .commit(a_commit), .commit_pc(a_commit_pc), .halted(a_halted), .halt_pc(a_halt_pc),
    .cycle_cnt(a_cycle_cnt), .instret(a_instret)
  );

  exu_seq #(.XLEN(64), .ALU_LAT(3), .CNT_W(64)) dut_b (
    .clk(clk), .rstn(b_rstn), .in_valid(b_valid), .in_ready(b_ready),
    .in_pc(b_pc), .in_src1(b_src1), .in_imm(b_imm), .in_rd(b_rd),
    .in_add(b_add), .in_ebreak(b_ebreak),
    .alu_src1(b_alu_src1), .alu_imm(b_alu_imm), .alu_add(b_alu_add), .alu_result(b_alu_result),
    .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .commit(b_commit), .commit_pc(b_commit_pc), .halted(b_halted), .halt_pc(b_halt_pc),
    .cycle_cnt(b_cycle_cnt), .instret(b_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  logic [63:0] bb_src [3] = '{64'h100, 64'h200, 64'hFFFF};
  logic [63:0] bb_imm [3] = '{64'h1,   64'h22,  64'h1};
  logic [4:0]  bb_rd  [3] = '{5'd1,    5'd2,    5'd31};
  logic [63:0] bb_exp [3] = '{64'h101, 64'h222, 64'h10000};

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    // ---------------- A: reset state
    tick(); tick();
    chk("a_rst_ready", a_ready, 1);
    chk("a_rst_alu_add", a_alu_add, 0);
    chk("a_rst_alu_src1", a_alu_src1, 0);
    chk("a_rst_wb_en", a_wb_en, 0);
    chk("a_rst_commit", a_commit, 0);
    chk("a_rst_halted", a_halted, 0);
    chk("a_rst_cycle", a_cycle_cnt, 0);
    chk("a_rst_instret", a_instret, 0);
    a_rstn = 1'b1;
    ncyc = 0;

    // ---------------- A: single addi
    a_pc = 64'h80000000; a_src1 = 64'h10; a_imm = 64'h5; a_rd = 5'd3; a_add = 1'b1; a_valid = 1'b1;
    tick();
    chk("a1_exec_add", a_alu_add, 1);
    chk("a1_exec_src1", a_alu_src1, 64'h10);
    chk("a1_exec_imm", a_alu_imm, 64'h5);
    chk("a1_exec_ready", a_ready, 0);
    a_valid = 1'b0; a_src1 = 64'hDEAD; a_imm = 64'hBEEF;
    tick();
    chk("a1_wb_en", a_wb_en, 1);
    chk("a1_wb_rd", a_wb_rd, 3);
    chk("a1_wb_data", a_wb_data, 64'h15);
    chk("a1_commit", a_commit, 1);
    chk("a1_commit_pc", a_commit_pc, 64'h80000000);
    chk("a1_instret", a_instret, 1);
    chk("a1_wb_ready", a_ready, 0);
    tick();
    chk("a1_idle_ready", a_ready, 1);
    chk("a1_idle_commit", a_commit, 0);
    chk("a1_idle_wb_en", a_wb_en, 0);
    chk("a1_hold_wb_data", a_wb_data, 64'h15);
    chk("a1_cycle", a_cycle_cnt, 64'(ncyc));

    // ---------------- A: back-to-back with in_valid held high
    for (int k = 0; k < 3; k++) begin
      a_src1 = bb_src[k]; a_imm = bb_imm[k]; a_rd = bb_rd[k];
      a_pc = 64'h80000100 + 64'(4 * k); a_valid = 1'b1;
      chk("bb_ready", a_ready, 1);
      tick();
      chk("bb_exec_src1", a_alu_src1, bb_src[k]);
      a_src1 = {$urandom, $urandom}; a_imm = {$urandom, $urandom}; a_rd = 5'd9;
      tick();
      chk("bb_wb_data", a_wb_data, bb_exp[k]);
      chk("bb_wb_rd", a_wb_rd, 64'(bb_rd[k]));
      chk("bb_commit", a_commit, 1);
      chk("bb_commit_pc", a_commit_pc, 64'h80000100 + 64'(4 * k));
      tick();
    end
    a_valid = 1'b0;
    chk("bb_instret", a_instret, 4);

    // ---------------- A: addi to x0
    a_src1 = 64'h1; a_imm = 64'h1; a_rd = 5'd0; a_add = 1'b1; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    chk("x0_commit", a_commit, 1);
    chk("x0_wb_en", a_wb_en, 0);
    chk("x0_wb_data", a_wb_data, 64'h2);
    tick();
    chk("x0_instret", a_instret, 5);

    // ---------------- A: ebreak (with add also set) then frozen HALT
    a_pc = 64'h80000010; a_ebreak = 1'b1; a_add = 1'b1; a_valid = 1'b1;
    tick();
    chk("eb_halted", a_halted, 1);
    chk("eb_halt_pc", a_halt_pc, 64'h80000010);
    chk("eb_instret", a_instret, 6);
    chk("eb_ready", a_ready, 0);
    chk("eb_alu_add", a_alu_add, 0);
    chk("eb_cycle", a_cycle_cnt, 64'(ncyc));
    halt_cyc = ncyc;
    a_ebreak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_commit", a_commit, 0);
      chk("halt_wb_en", a_wb_en, 0);
    end
    chk("halt_cycle_frozen", a_cycle_cnt, 64'(halt_cyc));
    chk("halt_instret_frozen", a_instret, 6);
    chk("halt_sticky", a_halted, 1);
    chk("halt_ready", a_ready, 0);

    // ---------------- A: reset out of HALT
    a_rstn = 1'b0; a_valid = 1'b0;
    tick();
    chk("halt_rst_halted", a_halted, 0);
    chk("halt_rst_halt_pc", a_halt_pc, 0);
    chk("halt_rst_ready", a_ready, 1);
    chk("halt_rst_instret", a_instret, 0);
    chk("halt_rst_cycle", a_cycle_cnt, 0);
    chk("halt_rst_commit_pc", a_commit_pc, 0);

    // ---------------- B: negative immediate, ALU_LAT = 3
    chk("b_rst_ready", b_ready, 1);
    chk("b_rst_instret", b_instret, 0);
    b_rstn = 1'b1;
    b_src1 = 64'h1; b_imm = 64'hFFFFFFFFFFFFFFFF; b_rd = 5'd5; b_add = 1'b1;
    b_pc = 64'h80000040; b_valid = 1'b1;
    tick();
    b_valid = 1'b0; b_src1 = 64'h55;
    chk("b_exec1_add", b_alu_add, 1);
    tick();
    chk("b_exec2_add", b_alu_add, 1);
    chk("b_exec2_commit", b_commit, 0);
    tick();
    chk("b_exec3_add", b_alu_add, 1);
    chk("b_exec3_commit", b_commit, 0);
    tick();
    chk("b_wb_commit", b_commit, 1);
    chk("b_wb_en", b_wb_en, 1);
    chk("b_wb_data", b_wb_data, 0);
    chk("b_wb_rd", b_wb_rd, 5);
    chk("b_wb_alu_add", b_alu_add, 0);
    tick();
    chk("b_idle_ready", b_ready, 1);

    // ---------------- B: reset mid-EXEC
    b_src1 = 64'h7; b_imm = 64'h1; b_rd = 5'd6; b_pc = 64'h80000044; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("b_mid_exec_add", b_alu_add, 1);
    b_rstn = 1'b0;
    tick();
    chk("b_mid_rst_alu_add", b_alu_add, 0);
    chk("b_mid_rst_alu_src1", b_alu_src1, 0);
    chk("b_mid_rst_alu_imm", b_alu_imm, 0);
    chk("b_mid_rst_wb_data", b_wb_data, 0);
    chk("b_mid_rst_wb_rd", b_wb_rd, 0);
    chk("b_mid_rst_commit_pc", b_commit_pc, 0);
    chk("b_mid_rst_instret", b_instret, 0);
    chk("b_mid_rst_cycle", b_cycle_cnt, 0);
    chk("b_mid_rst_ready", b_ready, 1);
    b_rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_abort_commit", b_commit, 0);
      chk("b_abort_wb_en", b_wb_en, 0);
    end
    chk("b_abort_instret", b_instret, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
